// File: rtl/tcp_stream_demux_pkg.sv
// Shared constants, field offsets and state encodings for the TCP receive demux.
// Optional TCP_STATS_EN adds per-channel byte/drop counters.
package tcp_stream_demux_pkg;

    typedef enum logic [2:0] {
        P_IDLE,
        P_ETH,
        P_IP,
        P_TCP,
        P_PAYLOAD,
        P_DISCARD
    } parse_t;

    typedef enum logic [1:0] {
        CH_CLOSED,
        CH_OPEN,
        CH_FINRX
    } chan_t;

    localparam logic [15:0] ETYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  PROTO_TCP  = 8'd6;

    // Absolute frame offsets
    localparam logic [15:0] OFF_ETYPE_HI = 16'd12;
    localparam logic [15:0] OFF_ETYPE_LO = 16'd13;
    localparam logic [15:0] OFF_IHL      = 16'd14;
    localparam logic [15:0] OFF_TOTLEN   = 16'd16;
    localparam logic [15:0] OFF_PROTO    = 16'd23;
    localparam logic [15:0] OFF_SRC_IP   = 16'd26;
    localparam logic [15:0] ETH_HDR_LEN  = 16'd14;

    // Offsets relative to the TCP header start
    localparam logic [15:0] T_DPORT_HI = 16'd2;
    localparam logic [15:0] T_DPORT_LO = 16'd3;
    localparam logic [15:0] T_SEQ      = 16'd4;
    localparam logic [15:0] T_DOFF     = 16'd12;
    localparam logic [15:0] T_FLAGS    = 16'd13;

    localparam int FLAG_FIN = 0;
    localparam int FLAG_SYN = 1;
    localparam int FLAG_RST = 2;

    // Payload length in 16-bit unsigned; an underflow clamps to zero.
    function automatic logic [15:0] pay_len(
        input logic [15:0] totlen,
        input logic [3:0]  ihl,
        input logic [3:0]  doff
    );
        logic [15:0] hdr;
        hdr = {10'd0, ihl, 2'b00} + {10'd0, doff, 2'b00};
        return (totlen > hdr) ? (totlen - hdr) : 16'd0;
    endfunction

endpackage

// File: rtl/tcp_stream_demux_chan_tracker.sv
// Per-connection state (CLOSED/OPEN/FINRX) and expected sequence number.
// With TCP_STATS_EN it also keeps accepted-byte and dropped-segment counters.
module tcp_chan_tracker
    import tcp_stream_demux_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        hdr_we,
    input  logic        syn,
    input  logic        rst_seg,
    input  logic        fin_now,
    input  logic [31:0] seq,
    input  logic        byte_we,
    input  logic        fin_last,
`ifdef TCP_STATS_EN
    input  logic        drop,
    output logic [31:0] bytes,
    output logic [15:0] drops,
`endif
    output chan_t       state,
    output logic [31:0] exp_seq
);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CH_CLOSED;
            exp_seq <= '0;
        end else if (hdr_we) begin
            if (syn) begin
                state   <= CH_OPEN;
                exp_seq <= seq + 32'd1;
            end else if (rst_seg) begin
                state <= CH_CLOSED;
            end else if (fin_now) begin
                state   <= CH_FINRX;
                exp_seq <= exp_seq + 32'd1;
            end
        end else if (byte_we) begin
            // FIN riding on data consumes one extra sequence number after the last byte
            exp_seq <= exp_seq + (fin_last ? 32'd2 : 32'd1);
            if (fin_last) state <= CH_FINRX;
        end
    end

`ifdef TCP_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            bytes <= '0;
            drops <= '0;
        end else if (hdr_we && syn) begin
            bytes <= '0;
            drops <= drop ? 16'd1 : 16'd0;
        end else begin
            if (byte_we) bytes <= bytes + 32'd1;
            if (hdr_we && drop && drops != 16'hFFFF) drops <= drops + 16'd1;
        end
    end
`endif

endmodule

// File: rtl/tcp_stream_demux.sv
// Ethernet/IPv4/TCP header parser, channel matcher and in-order payload output.
// Define TCP_STATS_EN to expose statBytes/statDrops.
module tcp_stream_demux
    import tcp_stream_demux_pkg::*;
#(
    parameter int          N_CHAN = 4,
    parameter logic [15:0] PORT   = 16'd80,
    parameter logic [47:0] MAC    = 48'hC471FEC856BF,
    localparam int         CW     = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  dataValid,
    input  logic [7:0]            data,
    input  logic                  newpkt,
    input  logic [N_CHAN-1:0]     cfg_en,
    input  logic [32*N_CHAN-1:0]  cfg_ip,
    input  logic [16*N_CHAN-1:0]  cfg_port,
    output logic                  outDataValid,
    output logic [7:0]            outData,
    output logic [CW-1:0]         outChan,
    output logic                  dropPulse,
`ifdef TCP_STATS_EN
    output logic [32*N_CHAN-1:0]  statBytes,
    output logic [16*N_CHAN-1:0]  statDrops,
`endif
    output logic [N_CHAN-1:0]     chanOpen
);

    parse_t      st_q, st_d, cur;
    logic [15:0] cnt_q, idx, tcp_base, toff, hdr_last, pay, rem_q, totlen_q;
    logic [3:0]  ihl_q, doff_q;
    logic [31:0] sip_q, seq_q, sel_exp;
    logic [15:0] sport_q;
    logic [7:0]  dport_hi_q, mac_b;
    logic        go_q, fin_pend_q, hit, accept;
    logic        hdr_we, byte_we, drop, fin_now, fin_last;
    logic [CW-1:0] hit_ch, ch_q;
    chan_t       sel_st;
    chan_t       ch_st  [N_CHAN];
    logic [31:0] ch_exp [N_CHAN];

    // newpkt restarts the frame at byte 0 from any state
    assign cur      = newpkt ? P_ETH : st_q;
    assign idx      = newpkt ? 16'd0 : cnt_q;
    assign tcp_base = ETH_HDR_LEN + {10'd0, ihl_q, 2'b00};
    assign toff     = idx - tcp_base;
    assign hdr_last = {10'd0, doff_q, 2'b00} - 16'd1;
    assign mac_b    = 8'(MAC >> {3'd5 - idx[2:0], 3'b000});
    assign pay      = pay_len(totlen_q, ihl_q, doff_q);

    // Lowest enabled channel whose tuple matches wins
    always_comb begin
        hit     = 1'b0;
        hit_ch  = '0;
        sel_st  = CH_CLOSED;
        sel_exp = '0;
        for (int k = N_CHAN - 1; k >= 0; k--) begin
            if (cfg_en[k] && cfg_ip[32*k +: 32] == sip_q &&
                cfg_port[16*k +: 16] == sport_q) begin
                hit     = 1'b1;
                hit_ch  = CW'(k);
                sel_st  = ch_st[k];
                sel_exp = ch_exp[k];
            end
        end
    end

    assign accept = hit && !data[FLAG_SYN] && !data[FLAG_RST] &&
                    sel_st == CH_OPEN && seq_q == sel_exp;

    always_comb begin
        st_d     = st_q;
        hdr_we   = 1'b0;
        byte_we  = 1'b0;
        drop     = 1'b0;
        fin_now  = 1'b0;
        fin_last = 1'b0;
        if (dataValid) begin
            st_d = cur;
            unique case (cur)
                P_ETH: begin
                    if (idx < 16'd6 && data != mac_b)
                        st_d = P_DISCARD;
                    else if (idx == OFF_ETYPE_HI && data != ETYPE_IPV4[15:8])
                        st_d = P_DISCARD;
                    else if (idx == OFF_ETYPE_LO)
                        st_d = (data == ETYPE_IPV4[7:0]) ? P_IP : P_DISCARD;
                end
                P_IP: begin
                    if (idx == OFF_IHL && data[3:0] < 4'd5)
                        st_d = P_DISCARD;
                    else if (idx == OFF_PROTO && data != PROTO_TCP)
                        st_d = P_DISCARD;
                    else if (idx == tcp_base - 16'd1)
                        st_d = P_TCP;
                end
                P_TCP: begin
                    if (toff == T_DPORT_LO && {dport_hi_q, data} != PORT) begin
                        st_d = P_DISCARD;
                    end else if (toff == T_FLAGS) begin
                        if (!hit) begin
                            st_d = P_DISCARD;
                        end else begin
                            hdr_we  = 1'b1;
                            drop    = pay != 16'd0 && !accept;
                            fin_now = accept && data[FLAG_FIN] && pay == 16'd0;
                        end
                    end else if (toff > T_FLAGS && toff == hdr_last) begin
                        st_d = go_q ? P_PAYLOAD : P_DISCARD;
                    end
                end
                P_PAYLOAD: begin
                    byte_we = 1'b1;
                    if (rem_q == 16'd1) begin
                        st_d     = P_DISCARD;
                        fin_last = fin_pend_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            st_q <= P_IDLE;
            cnt_q <= '0;
        end else begin
            st_q <= st_d;
            if (dataValid) cnt_q <= idx + 16'd1;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            ihl_q      <= '0;
            doff_q     <= '0;
            totlen_q   <= '0;
            sip_q      <= '0;
            sport_q    <= '0;
            dport_hi_q <= '0;
            seq_q      <= '0;
            go_q       <= 1'b0;
            fin_pend_q <= 1'b0;
            rem_q      <= '0;
            ch_q       <= '0;
        end else if (dataValid) begin
            if (cur == P_IP) begin
                if (idx == OFF_IHL) ihl_q <= data[3:0];
                if (idx == OFF_TOTLEN || idx == OFF_TOTLEN + 16'd1)
                    totlen_q <= {totlen_q[7:0], data};
                if (idx >= OFF_SRC_IP && idx < OFF_SRC_IP + 16'd4)
                    sip_q <= {sip_q[23:0], data};
            end
            if (cur == P_TCP) begin
                if (toff < T_DPORT_HI) sport_q <= {sport_q[7:0], data};
                if (toff == T_DPORT_HI) dport_hi_q <= data;
                if (toff >= T_SEQ && toff < T_SEQ + 16'd4)
                    seq_q <= {seq_q[23:0], data};
                if (toff == T_DOFF) doff_q <= data[7:4];
                if (hdr_we) begin
                    go_q       <= accept && pay != 16'd0;
                    fin_pend_q <= accept && data[FLAG_FIN] && pay != 16'd0;
                    rem_q      <= pay;
                    ch_q       <= hit_ch;
                end
            end
            if (byte_we) rem_q <= rem_q - 16'd1;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            outDataValid <= 1'b0;
            outData      <= '0;
            outChan      <= '0;
            dropPulse    <= 1'b0;
        end else begin
            outDataValid <= byte_we;
            dropPulse    <= drop;
            if (byte_we) begin
                outData <= data;
                outChan <= ch_q;
            end
        end
    end

    for (genvar k = 0; k < N_CHAN; k++) begin : g_chan
        tcp_chan_tracker u_trk (
            .clk      (CLOCK),
            .reset    (RESET),
            .hdr_we   (hdr_we && hit_ch == CW'(k)),
            .syn      (data[FLAG_SYN]),
            .rst_seg  (data[FLAG_RST]),
            .fin_now  (fin_now),
            .seq      (seq_q),
            .byte_we  (byte_we && ch_q == CW'(k)),
            .fin_last (fin_last),
`ifdef TCP_STATS_EN
            .drop     (drop),
            .bytes    (statBytes[32*k +: 32]),
            .drops    (statDrops[16*k +: 16]),
`endif
            .state    (ch_st[k]),
            .exp_seq  (ch_exp[k])
        );
        assign chanOpen[k] = (ch_st[k] == CH_OPEN);
    end

endmodule

// File: tb/tb_tcp_stream_demux.sv
// Scoreboard bench for tcp_stream_demux: builds Ethernet/IPv4/TCP frames,
// predicts accepted payload bytes and drop pulses, compares DUT output.
module tb_tcp_stream_demux;

    localparam int N = 4;
    localparam logic [47:0] MAC_OK = 48'hC471FEC856BF;

    logic           CLOCK = 1'b0;
    logic           RESET = 1'b1;
    logic           dataValid = 1'b0;
    logic           newpkt = 1'b0;
    logic [7:0]     data = '0;
    logic [N-1:0]   cfg_en = '0;
    logic [32*N-1:0] cfg_ip;
    logic [16*N-1:0] cfg_port;
    logic           outDataValid;
    logic [7:0]     outData;
    logic [1:0]     outChan;
    logic           dropPulse;
    logic [N-1:0]   chanOpen;
`ifdef TCP_STATS_EN
    logic [32*N-1:0] statBytes;
    logic [16*N-1:0] statDrops;
`endif

    always #5 CLOCK = ~CLOCK;

    tcp_stream_demux dut (
        .CLOCK        (CLOCK),
        .RESET        (RESET),
        .dataValid    (dataValid),
        .data         (data),
        .newpkt       (newpkt),
        .cfg_en       (cfg_en),
        .cfg_ip       (cfg_ip),
        .cfg_port     (cfg_port),
        .outDataValid (outDataValid),
        .outData      (outData),
        .outChan      (outChan),
        .dropPulse    (dropPulse),
`ifdef TCP_STATS_EN
        .statBytes    (statBytes),
        .statDrops    (statDrops),
`endif
        .chanOpen     (chanOpen)
    );

    typedef struct packed {
        logic [1:0]  ch;
        logic [7:0]  d;
        logic [31:0] cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [7:0]  fr[$];
    logic [7:0]  pay[$];
    logic [31:0] ips[N];
    logic [15:0] pts[N];
    int n_cmp = 0, n_bad = 0, cyc = 0;
    int drops = 0, drop_cyc = 0, flag_cyc = 0, n_out = 0;
    int d0, o0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    always @(posedge CLOCK) cyc <= cyc + 1;

    always @(negedge CLOCK) begin
        if (outDataValid) begin
            n_out++;
            if (sb.size() == 0) begin
                check("spurious_byte", 64'(outDataValid), 64'd0);
            end else begin
                e = sb.pop_front();
                check("byte", {outChan, outData}, {e.ch, e.d});
                check("latency", 64'(cyc), 64'(e.cyc));
            end
        end
        if (dropPulse) begin
            drops++;
            drop_cyc = cyc;
        end
    end

    task automatic build(input logic [47:0] dmac, input logic [31:0] sip,
                         input logic [15:0] sp, input logic [15:0] dp,
                         input logic [31:0] seq, input logic [7:0] flg,
                         input int pad);
        logic [15:0] tl;
        tl = 16'(40 + pay.size());
        fr.delete();
        for (int i = 5; i >= 0; i--) fr.push_back(dmac[8*i +: 8]);
        fr.push_back(8'h02);
        for (int i = 0; i < 5; i++) fr.push_back(8'h11);
        fr.push_back(8'h08); fr.push_back(8'h00);
        fr.push_back(8'h45); fr.push_back(8'h00);
        fr.push_back(tl[15:8]); fr.push_back(tl[7:0]);
        fr.push_back(8'h00); fr.push_back(8'h00);
        fr.push_back(8'h40); fr.push_back(8'h00);
        fr.push_back(8'h40); fr.push_back(8'h06);
        fr.push_back(8'h00); fr.push_back(8'h00);
        for (int i = 3; i >= 0; i--) fr.push_back(sip[8*i +: 8]);
        fr.push_back(8'hC0); fr.push_back(8'hA8);
        fr.push_back(8'h01); fr.push_back(8'h02);
        fr.push_back(sp[15:8]); fr.push_back(sp[7:0]);
        fr.push_back(dp[15:8]); fr.push_back(dp[7:0]);
        for (int i = 3; i >= 0; i--) fr.push_back(seq[8*i +: 8]);
        for (int i = 0; i < 4; i++) fr.push_back(8'h00);
        fr.push_back(8'h50); fr.push_back(flg);
        fr.push_back(8'h20); fr.push_back(8'h00);
        for (int i = 0; i < 4; i++) fr.push_back(8'h00);
        foreach (pay[i]) fr.push_back(pay[i]);
        for (int i = 0; i < pad; i++) fr.push_back(8'h00);
    endtask

    // ok: payload is expected on outData for channel ch
    task automatic send(input int ch, input bit ok, input int stop_at);
        for (int i = 0; i < fr.size(); i++) begin
            if ($urandom_range(0, 4) == 0) begin
                @(posedge CLOCK); #1;
                dataValid = 1'b0;
                newpkt = 1'b0;
            end
            @(posedge CLOCK); #1;
            dataValid = 1'b1;
            newpkt = (i == 0);
            data = fr[i];
            if (i == 47) flag_cyc = cyc;
            if (ok && i >= 54 && i < 54 + pay.size())
                sb.push_back('{ch: 2'(ch), d: fr[i], cyc: 32'(cyc + 1)});
            if (i == stop_at) break;
        end
        @(posedge CLOCK); #1;
        dataValid = 1'b0;
        newpkt = 1'b0;
    endtask

    task automatic seg(input int ch, input logic [31:0] seq, input logic [7:0] flg, input bit ok);
        build(MAC_OK, ips[ch], pts[ch], 16'd80, seq, flg, 0);
        send(ch, ok, -1);
    endtask

    task automatic settle();
        repeat (4) @(posedge CLOCK);
        #1;
    endtask

    task automatic mark();
        d0 = drops;
        o0 = n_out;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ips = '{32'h0AD2321C, 32'h0A000001, 32'h0A000002, 32'h0A000003};
        pts = '{16'd57284, 16'd1111, 16'd2222, 16'd3333};
        for (int k = 0; k < N; k++) begin
            cfg_ip[32*k +: 32] = ips[k];
            cfg_port[16*k +: 16] = pts[k];
        end
        repeat (3) @(posedge CLOCK);
        @(negedge CLOCK);
        check("rst_valid", 64'(outDataValid), 64'd0);
        check("rst_data", 64'(outData), 64'd0);
        check("rst_chan", 64'(outChan), 64'd0);
        check("rst_drop", 64'(dropPulse), 64'd0);
        check("rst_open", 64'(chanOpen), 64'd0);
        @(posedge CLOCK); #1;
        RESET = 1'b0;

        // connect, one byte, FIN, RST on chan 0 only
        cfg_en = 4'b0001;
        mark();
        pay.delete();
        seg(0, 32'd1000, 8'h02, 1'b0);
        settle();
        check("t1_open", 64'(chanOpen), 64'b0001);
        pay = '{8'h20};
        seg(0, 32'd1001, 8'h18, 1'b1);
        pay.delete();
        seg(0, 32'd1002, 8'h11, 1'b0);
        settle();
        check("t1_finrx", 64'(chanOpen), 64'b0000);
        seg(0, 32'd1003, 8'h04, 1'b0);
        settle();
        check("t1_bytes", 64'(n_out - o0), 64'd1);
        check("t1_drops", 64'(drops - d0), 64'd0);
        check("t1_closed", 64'(chanOpen), 64'b0000);

        // interleaved chans 1 and 2
        cfg_en = 4'b0111;
        mark();
        pay.delete();
        seg(1, 32'd5000, 8'h02, 1'b0);
        seg(2, 32'd9000, 8'h02, 1'b0);
        settle();
        check("t2_open", 64'(chanOpen), 64'b0110);
        for (int r = 0; r < 3; r++) begin
            pay = '{8'h61, 8'h62, 8'h63};
            seg(1, 32'(5001 + 3 * r), 8'h18, 1'b1);
            pay = '{8'h78, 8'h79, 8'h7A};
            seg(2, 32'(9001 + 3 * r), 8'h18, 1'b1);
        end
        settle();
        check("t2_bytes", 64'(n_out - o0), 64'd18);
        check("t2_drain", 64'(sb.size()), 64'd0);
        check("t2_drops", 64'(drops - d0), 64'd0);

        // retransmit on chan 1 (exp is 5010)
        mark();
        pay = '{8'h61, 8'h62, 8'h63};
        seg(1, 32'd5007, 8'h18, 1'b0);
        settle();
        check("t3_drops", 64'(drops - d0), 64'd1);
        check("t3_drop_time", 64'(drop_cyc), 64'(flag_cyc + 1));
        check("t3_no_bytes", 64'(n_out - o0), 64'd0);
        seg(1, 32'd5010, 8'h18, 1'b1);
        settle();
        check("t3_resume", 64'(n_out - o0), 64'd3);

        // pad, wrong MAC, wrong port, disabled channel (chan 1 exp is 5013)
        mark();
        pay = '{8'h50, 8'h41, 8'h44, 8'h44, 8'h45, 8'h44};
        build(MAC_OK, ips[1], pts[1], 16'd80, 32'd5013, 8'h18, 10);
        send(1, 1'b1, -1);
        pay = '{8'h7A, 8'h7A};
        build(48'hC471FEC856BE, ips[1], pts[1], 16'd80, 32'd5019, 8'h18, 0);
        send(1, 1'b0, -1);
        build(MAC_OK, ips[1], pts[1], 16'd81, 32'd5019, 8'h18, 0);
        send(1, 1'b0, -1);
        seg(3, 32'd1, 8'h18, 1'b0);
        settle();
        check("t4_pad_bytes", 64'(n_out - o0), 64'd6);
        check("t4_no_drop", 64'(drops - d0), 64'd0);
        seg(1, 32'd5019, 8'h18, 1'b1);
        settle();
        check("t4_after", 64'(n_out - o0), 64'd8);

        // sequence wrap on chan 3
        cfg_en = 4'b1111;
        mark();
        pay.delete();
        seg(3, 32'hFFFF_FFFE, 8'h02, 1'b0);
        pay = '{8'h01, 8'h02, 8'h03, 8'h04};
        seg(3, 32'hFFFF_FFFF, 8'h18, 1'b1);
        pay = '{8'h05, 8'h06};
        seg(3, 32'h0000_0003, 8'h18, 1'b1);
        settle();
        check("t5_bytes", 64'(n_out - o0), 64'd6);
        check("t5_drops", 64'(drops - d0), 64'd0);

        // SYN carrying payload, then a truncated frame on chan 2
        mark();
        pay = '{8'h71, 8'h71};
        seg(2, 32'd7000, 8'h02, 1'b0);
        pay = '{8'h72, 8'h72};
        seg(2, 32'd7001, 8'h18, 1'b1);
        pay = '{8'h73, 8'h73};
        build(MAC_OK, ips[2], pts[2], 16'd80, 32'd7003, 8'h18, 0);
        send(2, 1'b0, 40);
        seg(2, 32'd7003, 8'h18, 1'b1);
        settle();
        check("t7_drops", 64'(drops - d0), 64'd1);
        check("t7_bytes", 64'(n_out - o0), 64'd4);

        // reset mid-payload on chan 0
        pay.delete();
        seg(0, 32'd100, 8'h02, 1'b0);
        pay = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
        build(MAC_OK, ips[0], pts[0], 16'd80, 32'd101, 8'h18, 0);
        send(0, 1'b1, 56);
        RESET = 1'b1;
        @(posedge CLOCK);
        @(negedge CLOCK);
        check("t6_rst_valid", 64'(outDataValid), 64'd0);
        check("t6_rst_drop", 64'(dropPulse), 64'd0);
        check("t6_rst_open", 64'(chanOpen), 64'd0);
        check("t6_drain", 64'(sb.size()), 64'd0);
        @(posedge CLOCK); #1;
        RESET = 1'b0;
        mark();
        seg(0, 32'd101, 8'h18, 1'b0);
        settle();
        check("t6_resend_drop", 64'(drops - d0), 64'd1);
        check("t6_resend_bytes", 64'(n_out - o0), 64'd0);
        pay.delete();
        seg(0, 32'd500, 8'h02, 1'b0);
        pay = '{8'h47, 8'h48};
        seg(0, 32'd501, 8'h18, 1'b1);
        settle();
        check("t6_reopen", 64'(chanOpen), 64'b0001);
        check("t6_bytes", 64'(n_out - o0), 64'd2);
        check("final_drain", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
